// File: rtl/note_sequencer.sv
// note_sequencer: walks a song ROM and plays one note per word.
// Each ROM word is {pitch[7:0], duration[4:0]}. A zero duration is the
// end-of-song marker. A note goes out as a duration load to an external
// tick-driven counter. The note sounds from the moment the counter reports
// running until the counter pulses done.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_tick                tempo tick (consumed by the external counter)
//   i_start, i_stop       playback control pulses; stop wins over start
//   i_loop                on end marker, restart at address 0
//   o_rom_addr            song ROM address; data returns one cycle later
//   i_rom_data            ROM word {pitch, duration}
//   o_dur_load, o_dur_value  load request / value for the duration counter
//   i_dur_done, i_dur_running  duration counter status
//   o_pitch, o_note_on    current note
//   o_busy                high whenever not idle
//   o_song_done           one-cycle pulse at end of a non-looping song
module note_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tick,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [12:0]       i_rom_data,
    output logic              o_dur_load,
    output logic [4:0]        o_dur_value,
    input  logic              i_dur_done,
    input  logic              i_dur_running,
    output logic [7:0]        o_pitch,
    output logic              o_note_on,
    output logic              o_busy,
    output logic              o_song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        LOAD,
        PLAY
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [7:0]        pitch, pitch_nxt;
    logic [4:0]        dur, dur_nxt;
    logic              dur_load, load_nxt;
    logic              note_on, on_nxt;
    logic              song_done, done_nxt;

    // The tick drives the duration counter directly. The sequencer only
    // watches i_dur_running, which already tells it when a load was taken.
    logic unused_tick;
    assign unused_tick = i_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            pitch     <= '0;
            dur       <= '0;
            dur_load  <= 1'b0;
            note_on   <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            pitch     <= pitch_nxt;
            dur       <= dur_nxt;
            dur_load  <= load_nxt;
            note_on   <= on_nxt;
            song_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        pitch_nxt = pitch;
        dur_nxt   = dur;
        load_nxt  = dur_load;
        on_nxt    = note_on;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start && !i_stop) begin
                    addr_nxt  = '0;
                    state_nxt = FETCH;
                end
            end
            // The address is already on the ROM port. The word comes back
            // during LATCH.
            FETCH: state_nxt = LATCH;
            LATCH: begin
                pitch_nxt = i_rom_data[12:5];
                dur_nxt   = i_rom_data[4:0];
                if (i_rom_data[4:0] != 5'd0) begin
                    load_nxt  = 1'b1;
                    state_nxt = LOAD;
                end else if (i_loop) begin
                    addr_nxt  = '0;
                    state_nxt = FETCH;
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            // Keep requesting until the counter has taken the load. That can
            // take up to a full tick period.
            LOAD: begin
                if (i_dur_running) begin
                    load_nxt  = 1'b0;
                    on_nxt    = 1'b1;
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (i_dur_done) begin
                    addr_nxt  = addr + ADDR_W'(1);
                    on_nxt    = 1'b0;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything. A counter already running finishes on
        // its own, and its done pulse then arrives in IDLE, where it is ignored.
        if (i_stop && state != IDLE) begin
            state_nxt = IDLE;
            load_nxt  = 1'b0;
            on_nxt    = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    assign o_rom_addr  = addr;
    assign o_dur_load  = dur_load;
    assign o_dur_value = dur;
    assign o_pitch     = pitch;
    assign o_note_on   = note_on;
    assign o_busy      = (state != IDLE);
    assign o_song_done = song_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer. Two instances are used: an 8-bit-address
// one for the song and control tests, and a 2-bit-address one that plays a
// full ROM continuously to show address wraparound. Each instance has a ROM
// model with one-cycle read latency and a tick-driven duration counter model.
module tb_note_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0, rst2_n = 1'b0;
    logic tick = 1'b0, tick_en = 1'b1;
    logic start = 1'b0, stop = 1'b0, loop = 1'b0, start2 = 1'b0;

    logic [7:0]  addr1;
    logic [1:0]  addr2;
    logic [12:0] data1, data2;
    logic        load1, load2, on1, on2, busy1, busy2, sdone1, sdone2;
    logic [4:0]  val1, val2;
    logic [7:0]  pitch1, pitch2;

    logic [1:0]  c_run = 2'b00, c_done = 2'b00;
    logic [4:0]  c_cnt [2];
    logic [1:0]  c_load;
    logic [4:0]  c_val [2];

    logic [12:0] rom1 [256];
    logic [12:0] rom2 [4];

    int n_chk = 0, n_bad = 0;

    always #5 clk = ~clk;

    note_sequencer #(.ADDR_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_start(start),
        .i_stop(stop), .i_loop(loop), .o_rom_addr(addr1), .i_rom_data(data1),
        .o_dur_load(load1), .o_dur_value(val1), .i_dur_done(c_done[0]),
        .i_dur_running(c_run[0]), .o_pitch(pitch1), .o_note_on(on1),
        .o_busy(busy1), .o_song_done(sdone1)
    );

    note_sequencer #(.ADDR_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_tick(tick), .i_start(start2),
        .i_stop(1'b0), .i_loop(1'b0), .o_rom_addr(addr2), .i_rom_data(data2),
        .o_dur_load(load2), .o_dur_value(val2), .i_dur_done(c_done[1]),
        .i_dur_running(c_run[1]), .o_pitch(pitch2), .o_note_on(on2),
        .o_busy(busy2), .o_song_done(sdone2)
    );

    // ROM: the word for an address appears the cycle after the address.
    always @(posedge clk) begin
        data1 <= rom1[addr1];
        data2 <= rom2[addr2];
    end

    // Duration counter: takes a load only on a tick while idle, counts down
    // one per tick, and pulses done on the tick that ends the count.
    assign c_load = {load2, load1};
    assign c_val[0] = val1;
    assign c_val[1] = val2;
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            c_done[k] <= 1'b0;
            if (tick) begin
                if (c_run[k]) begin
                    if (c_cnt[k] == 5'd1) begin
                        c_run[k]  <= 1'b0;
                        c_done[k] <= 1'b1;
                    end else begin
                        c_cnt[k] <= c_cnt[k] - 5'd1;
                    end
                end else if (c_load[k]) begin
                    c_run[k] <= 1'b1;
                    c_cnt[k] <= c_val[k];
                end
            end
        end
    end

    // Tick generator: one-cycle pulse every 4 cycles while enabled.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph = ph + 1;
            tick = tick_en && (ph % 4 == 0);
        end
    end

    // Note monitors. They log pitch and address at note start, and the
    // number of ticks seen while the note sounds.
    logic [7:0] p1_q[$], a1_q[$], p2_q[$], a2_q[$];
    int         t1_q[$];
    int         n1_ticks = 0, glitch1 = 0, sd1 = 0, sd2 = 0;
    logic       prev_on1 = 1'b0, prev_on2 = 1'b0;
    logic [7:0] prev_p1 = 8'd0;

    always @(negedge clk) begin
        if (sdone1) sd1++;
        if (on1 && !prev_on1) begin
            p1_q.push_back(pitch1);
            a1_q.push_back(addr1);
            n1_ticks = tick ? 1 : 0;
        end else if (on1) begin
            if (pitch1 != prev_p1) glitch1++;
            if (tick) n1_ticks++;
        end else if (prev_on1) begin
            t1_q.push_back(n1_ticks);
        end
        prev_on1 = on1;
        prev_p1  = pitch1;
    end

    always @(negedge clk) begin
        if (sdone2) sd2++;
        if (on2 && !prev_on2) begin
            p2_q.push_back(pitch2);
            a2_q.push_back({6'd0, addr2});
        end
        prev_on2 = on2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic wait_ctr_idle();
        for (int i = 0; i < 100 && c_run[0]; i++) begin @(posedge clk); #1; end
        chk("ctr_idle_to", {31'd0, c_run[0]}, 0);
    endtask

    initial begin
        int bp, bt, bs;
        logic ok;
        for (int i = 0; i < 256; i++) rom1[i] = 13'd0;
        rom1[0] = {8'd10, 5'd3};
        rom1[1] = {8'd20, 5'd1};
        rom1[2] = {8'd0,  5'd0};
        rom2[0] = {8'd31, 5'd2};
        rom2[1] = {8'd32, 5'd1};
        rom2[2] = {8'd33, 5'd2};
        rom2[3] = {8'd34, 5'd1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_note_on", on1, 0);
        chk("rst_dur_load", load1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_song_done", sdone1, 0);
        chk("rst_pitch", pitch1, 0);
        chk("rst_addr", addr1, 0);
        chk("rst_dur_val", val1, 0);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;

        // A: plain song; a start during playback must be ignored
        bp = p1_q.size(); bt = t1_q.size(); bs = sd1;
        pulse_start();
        for (int i = 0; i < 100 && p1_q.size() < bp + 1; i++) begin @(posedge clk); #1; end
        pulse_start();
        for (int i = 0; i < 200 && sd1 == bs; i++) begin @(posedge clk); #1; end
        chk("a_done_to", sd1 - bs, 1);
        @(posedge clk); #1;
        chk("a_busy", busy1, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("a_n_notes", p1_q.size() - bp, 2);
        chk("a_pitch0", p1_q[bp], 10);
        chk("a_pitch1", p1_q[bp+1], 20);
        chk("a_ticks0", t1_q[bt], 3);
        chk("a_ticks1", t1_q[bt+1], 1);
        chk("a_done_pulses", sd1 - bs, 1);
        chk("a_glitch", glitch1, 0);

        // B: looping song
        loop = 1'b1;
        bp = p1_q.size(); bs = sd1;
        pulse_start();
        for (int i = 0; i < 400 && p1_q.size() < bp + 4; i++) begin @(posedge clk); #1; end
        chk("b_n_notes", p1_q.size() >= bp + 4, 1);
        chk("b_p0", p1_q[bp],   10);
        chk("b_p1", p1_q[bp+1], 20);
        chk("b_p2", p1_q[bp+2], 10);
        chk("b_p3", p1_q[bp+3], 20);
        chk("b_a2", a1_q[bp+2], 0);
        chk("b_a3", a1_q[bp+3], 1);
        chk("b_no_done", sd1 - bs, 0);
        pulse_stop();
        loop = 1'b0;
        wait_ctr_idle();

        // C: stop during the second note
        bp = p1_q.size(); bs = sd1;
        pulse_start();
        for (int i = 0; i < 200 && p1_q.size() < bp + 2; i++) begin @(posedge clk); #1; end
        chk("c_note2_to", p1_q.size() >= bp + 2, 1);
        pulse_stop();
        chk("c_busy", busy1, 0);
        chk("c_note_on", on1, 0);
        chk("c_dur_load", load1, 0);
        chk("c_pitch_hold", pitch1, 20);
        repeat (30) @(posedge clk);
        #1;
        chk("c_still_off", on1, 0);
        chk("c_still_idle", busy1, 0);
        chk("c_no_done", sd1 - bs, 0);
        chk("c_no_more_notes", p1_q.size() - bp, 2);

        // D: tick held low during LOAD
        wait_ctr_idle();
        tick_en = 1'b0;
        pulse_start();
        for (int i = 0; i < 20 && !load1; i++) begin @(posedge clk); #1; end
        chk("d_load_to", load1, 1);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!load1 || val1 != 5'd3) ok = 1'b0;
        end
        chk("d_load_held", ok, 1);
        chk("d_not_on", on1, 0);
        tick_en = 1'b1;
        for (int i = 0; i < 20 && !on1; i++) begin @(posedge clk); #1; end
        chk("d_play_to", on1, 1);
        chk("d_pitch", pitch1, 10);
        chk("d_load_drop", load1, 0);
        pulse_stop();
        wait_ctr_idle();

        // E: async reset mid-note, then start+stop together from IDLE
        pulse_start();
        for (int i = 0; i < 100 && !on1; i++) begin @(posedge clk); #1; end
        chk("e_play_to", on1, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("e_rst_on", on1, 0);
        chk("e_rst_load", load1, 0);
        chk("e_rst_busy", busy1, 0);
        chk("e_rst_sdone", sdone1, 0);
        chk("e_rst_pitch", pitch1, 0);
        chk("e_rst_addr", addr1, 0);
        chk("e_rst_val", val1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("e_wait_idle", busy1, 0);
        wait_ctr_idle();
        start = 1'b1;
        stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop = 1'b0;
        chk("e_ss_idle", busy1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("e_ss_idle2", busy1, 0);

        // F: 2-bit address instance has been playing the whole time
        chk("f_n_notes", p2_q.size() >= 6, 1);
        chk("f_p0", p2_q[0], 31);
        chk("f_p1", p2_q[1], 32);
        chk("f_p2", p2_q[2], 33);
        chk("f_p3", p2_q[3], 34);
        chk("f_p4", p2_q[4], 31);
        chk("f_a3", a2_q[3], 3);
        chk("f_a4", a2_q[4], 0);
        chk("f_a5", a2_q[5], 1);
        chk("f_no_done", sd2, 0);
        chk("f_busy", busy2, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
